// File: rtl/step_periph_pkg.sv
// Shared constants for the step peripheral: button count and the default
// debounce threshold used by the peripheral top-level and the debouncer.
package step_periph_pkg;

    // Number of board push-buttons routed to the user core.
    localparam int BUTTON_COUNT    = 4;

    // Default number of consecutive synchronized cycles a new button level
    // must persist before it is accepted.
    localparam int DEBOUNCE_CYCLES = 16;

    // Width of the per-channel stability counter. The counter only has to
    // reach STABLE_CYCLES-1, so $clog2 of the threshold is enough. The floor
    // of 1 keeps the declaration legal even for an illegal threshold, so the
    // dedicated elaboration check is the one that reports the problem.
    function automatic int debounce_cnt_width(input int stable_cycles);
        if (stable_cycles < 2) begin
            return 1;
        end
        return $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit button conditioner: two-flop synchronizer, stability counter
// and registered press/release pulse generation. All state resets to 0
// asynchronously, and every output comes straight from a flop.
module debounce_channel
    import step_periph_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rose,
    output logic fell
);

    localparam int            CW      = debounce_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // A threshold below 2 cannot filter anything and would give a
    // zero-width counter, so refuse to elaborate.
    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("debounce_channel: STABLE_CYCLES must be 2 or more");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from the current one for
    // STABLE_CYCLES consecutive cycles; any agreeing cycle restarts the count,
    // so short glitches and chatter never reach the level register. The
    // edge pulses are registered alongside the level so they line up with
    // the first cycle of the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rose  <= 1'b0;
            fell  <= 1'b0;
        end else if (s2 == level) begin
            cnt  <= '0;
            rose <= 1'b0;
            fell <= 1'b0;
        end else if (cnt != CNT_MAX) begin
            cnt  <= cnt + 1'b1;
            rose <= 1'b0;
            fell <= 1'b0;
        end else begin
            level <= s2;
            cnt   <= '0;
            rose  <= s2;
            fell  <= ~s2;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer: one independent synchronizer, debouncer
// and edge detector per push-button, outputs packed back into vectors.
module button_debounce
    import step_periph_pkg::*;
#(
    parameter int WIDTH         = BUTTON_COUNT,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rose,
    output logic [WIDTH-1:0] fell
);

    // Channels share nothing but clock and reset, so simultaneous activity
    // on several buttons is handled in parallel and pulses may coincide.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .level (level[i]),
            .rose  (rose[i]),
            .fell  (fell[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with WIDTH=4, STABLE_CYCLES=4.
// Inputs change 1ns after a rising edge; outputs are sampled at that same
// point, i.e. they show the state produced by the edge just passed. A raw
// change driven there is first sampled at the next edge (E0), and the new
// level with its pulse appears at E0+5, i.e. on the 6th tick after the drive.
module tb_button_debounce;

    localparam int W  = 4;
    localparam int SC = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] level;
    logic [W-1:0] rose;
    logic [W-1:0] fell;

    int n_tests;
    int n_fail;

    button_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw),
        .level (level),
        .rose  (rose),
        .fell  (fell)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [W-1:0] e_lvl,
                               input logic [W-1:0] e_rose, input logic [W-1:0] e_fell);
        chk({tag, " level"}, level, e_lvl);
        chk({tag, " rose"},  rose,  e_rose);
        chk({tag, " fell"},  fell,  e_fell);
    endtask

    // Advance n clock edges, checking all outputs after each one.
    task automatic expect_ticks(input string tag, input int n, input logic [W-1:0] e_lvl,
                                input logic [W-1:0] e_rose, input logic [W-1:0] e_fell);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk_outputs($sformatf("%s t%0d", tag, k), e_lvl, e_rose, e_fell);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        raw     = 4'hF;

        // 1. Reset with all buttons pressed: everything stays low.
        #1;
        chk_outputs("reset_async", 4'h0, 4'h0, 4'h0);
        expect_ticks("reset_hold", 2, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        raw = 4'h0;
        expect_ticks("reset_after", 4, 4'h0, 4'h0, 4'h0);

        // 2. Clean press on channel 0.
        raw = 4'b0001;
        expect_ticks("press0_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        expect_ticks("press0_edge", 1, 4'b0001, 4'b0001, 4'b0000);
        expect_ticks("press0_hold", 3, 4'b0001, 4'b0000, 4'b0000);

        // 3a. Channel 1 high for only 3 cycles: rejected.
        raw = 4'b0011;
        expect_ticks("glitch3_hi", 3, 4'b0001, 4'b0000, 4'b0000);
        raw = 4'b0001;
        expect_ticks("glitch3_lo", 8, 4'b0001, 4'b0000, 4'b0000);

        // 3b. Channel 1 high for 4 cycles: one rose, then one fell.
        raw = 4'b0011;
        expect_ticks("glitch4_hi", 4, 4'b0001, 4'b0000, 4'b0000);
        raw = 4'b0001;
        expect_ticks("glitch4_pre", 1, 4'b0001, 4'b0000, 4'b0000);
        expect_ticks("glitch4_rose", 1, 4'b0011, 4'b0010, 4'b0000);
        expect_ticks("glitch4_mid", 3, 4'b0011, 4'b0000, 4'b0000);
        expect_ticks("glitch4_fell", 1, 4'b0001, 4'b0000, 4'b0010);
        expect_ticks("glitch4_post", 3, 4'b0001, 4'b0000, 4'b0000);

        // 4. Chatter on channel 2 for 20 cycles, then hold high.
        for (int i = 0; i < 20; i++) begin
            raw[2] = (i % 2 == 0);
            expect_ticks($sformatf("chatter%0d", i), 1, 4'b0001, 4'b0000, 4'b0000);
        end
        raw[2] = 1'b1;
        expect_ticks("chatter_wait", 5, 4'b0001, 4'b0000, 4'b0000);
        expect_ticks("chatter_rose", 1, 4'b0101, 4'b0100, 4'b0000);
        expect_ticks("chatter_hold", 2, 4'b0101, 4'b0000, 4'b0000);

        // Release channels 0 and 2 together: coincident fell pulses.
        raw = 4'b0000;
        expect_ticks("rel02_wait", 5, 4'b0101, 4'b0000, 4'b0000);
        expect_ticks("rel02_fell", 1, 4'b0000, 4'b0000, 4'b0101);
        expect_ticks("rel02_post", 2, 4'b0000, 4'b0000, 4'b0000);

        // 5. Channels 1 and 3 pressed together.
        raw = 4'b1010;
        expect_ticks("sim_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        expect_ticks("sim_rose", 1, 4'b1010, 4'b1010, 4'b0000);
        expect_ticks("sim_hold", 2, 4'b1010, 4'b0000, 4'b0000);
        raw = 4'b0000;
        expect_ticks("sim_rel_wait", 5, 4'b1010, 4'b0000, 4'b0000);
        expect_ticks("sim_rel_fell", 1, 4'b0000, 4'b0000, 4'b1010);
        expect_ticks("sim_rel_post", 2, 4'b0000, 4'b0000, 4'b0000);

        // 6a. Channel 3 accepted high, then reset asynchronously while held.
        raw = 4'b1000;
        expect_ticks("ch3_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        expect_ticks("ch3_rose", 1, 4'b1000, 4'b1000, 4'b0000);
        expect_ticks("ch3_hold", 1, 4'b1000, 4'b0000, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs("async_clear", 4'b0000, 4'b0000, 4'b0000);
        expect_ticks("rst_held", 2, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;

        // 6b. Raw still high after release; reset again mid-count at E0+2.
        expect_ticks("midcnt_pre", 2, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b1;
        expect_ticks("midcnt_rst", 1, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;

        // Normal rise after the final release with raw still high.
        expect_ticks("post_rst_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        expect_ticks("post_rst_rose", 1, 4'b1000, 4'b1000, 4'b0000);
        expect_ticks("post_rst_hold", 2, 4'b1000, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
